// File: rtl/cpu_alu_seq.sv
`timescale 1ns/1ps
// cpu_alu_seq: multi-cycle 6502-family ALU.
//   ADD/SUB/CMP run nibble-serial, least significant digit first. Binary and
//   BCD (decimal-mode) ADD/SUB are supported; logic, shift and inc/dec ops
//   finish in one cycle. Valid/ready handshakes on both sides.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous abort back to IDLE, pending result dropped
//   in_valid/in_ready   request handshake (in_ready high only in IDLE)
//   op, decimal_mode    operation code, D flag (ADD/SUB only)
//   operand_a/b         operands, carry_in = C flag
//   out_valid/out_ready result handshake, result held until taken
//   result, carry_out, overflow, negative, zero   result and flags
//   busy                high whenever not IDLE
//
// state | meaning
// IDLE  | waiting for a request, last result still on the outputs
// ARITH | stepping one 4-bit digit per clock through ADD/SUB/CMP
// DONE  | result valid, waiting for out_ready
module cpu_alu_seq #(
  parameter int WIDTH      = 8,
  parameter bit ENABLE_BCD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             decimal_mode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             negative,
  output logic             zero,
  output logic             busy
);

  localparam int NDIG = WIDTH / 4;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3,
                         OP_XOR = 4'h4, OP_ASL = 4'h5, OP_LSR = 4'h6, OP_ROL = 4'h7,
                         OP_ROR = 4'h8, OP_INC = 4'h9, OP_DEC = 4'hA, OP_PASSA = 4'hB,
                         OP_PASSB = 4'hC, OP_CMP = 4'hD;

  typedef enum logic [1:0] {IDLE, ARITH, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q, acc;
  logic             sub_q, dec_q, cmp_q, c_q, bc_q, am_q, bm_q;

  logic             is_cmp_op, is_arith_op, step_en, single_en, last_digit;
  logic [WIDTH-1:0] cur_a, cur_b, next_acc, single_res;
  logic [3:0]       sa, sb, dig;
  logic             ssub, sdec, scmp, sc, sbc, am, bm, nc, nbc, vflag, single_c;
  logic [4:0]       bin_s, dec_s;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    is_cmp_op   = (op >= OP_CMP);
    is_arith_op = (op == OP_ADD) || (op == OP_SUB) || is_cmp_op;
    step_en     = (state == ARITH) || ((state == IDLE) && in_valid && is_arith_op);
    single_en   = (state == IDLE) && in_valid && !is_arith_op;

    // The first digit is computed straight from the inputs on the accept edge,
    // which is what gives an NDIG-cycle latency for arithmetic.
    if (state == IDLE) begin
      cur_a = operand_a;
      cur_b = operand_b;
      ssub  = (op != OP_ADD);
      scmp  = is_cmp_op;
      sdec  = ENABLE_BCD && decimal_mode && !is_cmp_op;
      sc    = is_cmp_op ? 1'b1 : carry_in;
      sbc   = sc;
      am    = operand_a[WIDTH-1];
      bm    = operand_b[WIDTH-1];
    end else begin
      cur_a = a_q;
      cur_b = b_q;
      ssub  = sub_q;
      scmp  = cmp_q;
      sdec  = dec_q;
      sc    = c_q;
      sbc   = bc_q;
      am    = am_q;
      bm    = bm_q;
    end
    sa = cur_a[3:0];
    sb = cur_b[3:0];

    // Binary chain always runs; in decimal mode it only feeds V.
    bin_s = {1'b0, sa} + {1'b0, ssub ? ~sb : sb} + {4'b0, sbc};
    nbc   = bin_s[4];
    dig   = bin_s[3:0];
    nc    = bin_s[4];
    dec_s = '0;
    if (sdec && !ssub) begin
      dec_s = {1'b0, sa} + {1'b0, sb} + {4'b0, sc};
      if (dec_s > 5'd9) begin
        dig = dec_s[3:0] + 4'd6;
        nc  = 1'b1;
      end else begin
        dig = dec_s[3:0];
        nc  = 1'b0;
      end
    end else if (sdec) begin
      // sc is the carry flag, so the incoming borrow is its inverse.
      dec_s = {1'b0, sa} - {1'b0, sb} - {4'b0, ~sc};
      if (dec_s[4]) begin
        dig = dec_s[3:0] - 4'd6;
        nc  = 1'b0;
      end else begin
        dig = dec_s[3:0];
        nc  = 1'b1;
      end
    end

    // bin_s[3] is the binary result MSB only on the last digit, where V is used.
    if (scmp)
      vflag = 1'b0;
    else if (ssub)
      vflag = (am != bm) && (bin_s[3] != am);
    else
      vflag = (am == bm) && (bin_s[3] != am);

    next_acc   = ((state == IDLE) ? '0 : (acc >> 4)) | (WIDTH'(dig) << (WIDTH - 4));
    last_digit = (state == IDLE) ? (NDIG == 1) : (cnt == CW'(NDIG - 1));

    single_c = 1'b0;
    case (op)
      OP_AND:   single_res = operand_a & operand_b;
      OP_OR:    single_res = operand_a | operand_b;
      OP_XOR:   single_res = operand_a ^ operand_b;
      OP_ASL: begin
        single_res = operand_a << 1;
        single_c   = operand_a[WIDTH-1];
      end
      OP_LSR: begin
        single_res = operand_a >> 1;
        single_c   = operand_a[0];
      end
      OP_ROL: begin
        single_res = (operand_a << 1) | WIDTH'(carry_in);
        single_c   = operand_a[WIDTH-1];
      end
      OP_ROR: begin
        single_res = (operand_a >> 1) | (WIDTH'(carry_in) << (WIDTH - 1));
        single_c   = operand_a[0];
      end
      OP_INC:   single_res = operand_a + WIDTH'(1);
      OP_DEC:   single_res = operand_a - WIDTH'(1);
      OP_PASSA: single_res = operand_a;
      OP_PASSB: single_res = operand_b;
      default:  single_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      sub_q     <= 1'b0;
      dec_q     <= 1'b0;
      cmp_q     <= 1'b0;
      c_q       <= 1'b0;
      bc_q      <= 1'b0;
      am_q      <= 1'b0;
      bm_q      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
      zero      <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      if (step_en) begin
        a_q   <= cur_a >> 4;
        b_q   <= cur_b >> 4;
        acc   <= next_acc;
        sub_q <= ssub;
        dec_q <= sdec;
        cmp_q <= scmp;
        c_q   <= nc;
        bc_q  <= nbc;
        am_q  <= am;
        bm_q  <= bm;
        cnt   <= (state == IDLE) ? CW'(1) : cnt + CW'(1);
        if (last_digit) begin
          result    <= next_acc;
          carry_out <= nc;
          overflow  <= vflag;
          negative  <= next_acc[WIDTH-1];
          zero      <= (next_acc == '0);
        end
      end
      if (single_en) begin
        result    <= single_res;
        carry_out <= single_c;
        overflow  <= 1'b0;
        negative  <= single_res[WIDTH-1];
        zero      <= (single_res == '0);
      end
      case (state)
        IDLE:    if (in_valid) state <= (is_arith_op && !last_digit) ? ARITH : DONE;
        ARITH:   if (last_digit) state <= DONE;
        DONE:    if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_alu_seq.sv
`timescale 1ns/1ps
module tb_cpu_alu_seq;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        v;
    logic        n;
    logic        z;
  } res_t;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [3:0]  op_s = '0;
  logic        dec_s = 1'b0, cin_s = 1'b0;
  logic [15:0] a_s = '0, b_s = '0;
  logic        iv8 = 1'b0, iv16 = 1'b0, or8 = 1'b0, or16 = 1'b0;
  logic        ir8, ov8, c8, v8, n8, z8, busy8;
  logic        ir16, ov16, c16, v16, n16, z16, busy16;
  logic [7:0]  r8;
  logic [15:0] r16;

  int checks = 0, failures = 0;
  int cyc = 0;

  bit   pend8 = 0, pend16 = 0, ld8 = 0, ld16 = 0;
  res_t exp8 = '0, exp16 = '0;
  int   lat8 = 0, lat16 = 0, acc8 = 0, acc16 = 0;

  cpu_alu_seq #(.WIDTH(8), .ENABLE_BCD(1'b1)) u8 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv8), .in_ready(ir8),
    .op(op_s), .decimal_mode(dec_s), .operand_a(a_s[7:0]), .operand_b(b_s[7:0]),
    .carry_in(cin_s), .out_valid(ov8), .out_ready(or8), .result(r8),
    .carry_out(c8), .overflow(v8), .negative(n8), .zero(z8), .busy(busy8));

  cpu_alu_seq #(.WIDTH(16), .ENABLE_BCD(1'b1)) u16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv16), .in_ready(ir16),
    .op(op_s), .decimal_mode(dec_s), .operand_a(a_s), .operand_b(b_s),
    .carry_in(cin_s), .out_valid(ov16), .out_ready(or16), .result(r16),
    .carry_out(c16), .overflow(v16), .negative(n16), .zero(z16), .busy(busy16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint b2i(input longint v, input int nd);
    longint s = 0, f = 1;
    for (int i = 0; i < nd; i++) begin
      s += ((v >> (4 * i)) & 15) * f;
      f *= 10;
    end
    return s;
  endfunction

  function automatic longint i2b(input longint v, input int nd);
    longint s = 0, x = v;
    for (int i = 0; i < nd; i++) begin
      s |= (x % 10) << (4 * i);
      x /= 10;
    end
    return s;
  endfunction

  // Whole-word reference: integer arithmetic on the full operands, decimal
  // via conversion to plain integers, V from signed range overflow.
  function automatic res_t model(input int w, input logic [3:0] o, input logic d,
                                 input logic [15:0] a, input logic [15:0] b, input logic ci);
    longint m   = (longint'(1) << w) - 1;
    longint ua  = longint'(a) & m;
    longint ub  = longint'(b) & m;
    longint sa  = (ua > (m >> 1)) ? ua - (m + 1) : ua;
    longint sb  = (ub > (m >> 1)) ? ub - (m + 1) : ub;
    longint cl  = longint'(ci);
    longint p10 = 1;
    longint x   = 0;
    longint sx  = 0;
    int     nd  = w / 4;
    res_t   rr  = '0;
    for (int i = 0; i < nd; i++) p10 *= 10;
    case (o)
      4'h0: begin
        sx = sa + sb + cl;
        if (d) begin
          x = b2i(ua, nd) + b2i(ub, nd) + cl;
          rr.c = (x >= p10);
          rr.r = 16'(i2b(x % p10, nd));
        end else begin
          x = ua + ub + cl;
          rr.c = (x > m);
          rr.r = 16'(x & m);
        end
        rr.v = (sx > (m >> 1)) || (sx < -((m >> 1) + 1));
      end
      4'h1: begin
        sx = sa - sb - (1 - cl);
        if (d) begin
          x = b2i(ua, nd) - b2i(ub, nd) - (1 - cl);
          rr.c = (x >= 0);
          if (x < 0) x += p10;
          rr.r = 16'(i2b(x, nd));
        end else begin
          x = ua - ub - (1 - cl);
          rr.c = (x >= 0);
          rr.r = 16'(x & m);
        end
        rr.v = (sx > (m >> 1)) || (sx < -((m >> 1) + 1));
      end
      4'h2: rr.r = 16'(ua & ub);
      4'h3: rr.r = 16'(ua | ub);
      4'h4: rr.r = 16'(ua ^ ub);
      4'h5: begin rr.r = 16'((ua << 1) & m); rr.c = ((ua >> (w - 1)) & 1) != 0; end
      4'h6: begin rr.r = 16'(ua >> 1); rr.c = (ua & 1) != 0; end
      4'h7: begin rr.r = 16'(((ua << 1) | cl) & m); rr.c = ((ua >> (w - 1)) & 1) != 0; end
      4'h8: begin rr.r = 16'((ua >> 1) | (cl << (w - 1))); rr.c = (ua & 1) != 0; end
      4'h9: rr.r = 16'((ua + 1) & m);
      4'hA: rr.r = 16'((ua - 1) & m);
      4'hB: rr.r = 16'(ua);
      4'hC: rr.r = 16'(ub);
      default: begin
        rr.r = 16'((ua - ub) & m);
        rr.c = (ua >= ub);
      end
    endcase
    rr.n = rr.r[w-1];
    rr.z = (rr.r == 16'h0);
    return rr;
  endfunction

  task automatic cmp_one(input string nm, input bit pend, input res_t e, input int lat,
                         input int acc, input bit ld_i, input logic ov, input res_t a,
                         input logic ir, input logic bz, output bit ld_o);
    ld_o = ld_i;
    if (!pend) begin
      chk({nm, " out_valid without request"}, 32'(ov), 32'(0));
    end else if (ov) begin
      chk({nm, " result"}, 32'(a.r), 32'(e.r));
      chk({nm, " carry"}, 32'(a.c), 32'(e.c));
      chk({nm, " overflow"}, 32'(a.v), 32'(e.v));
      chk({nm, " negative"}, 32'(a.n), 32'(e.n));
      chk({nm, " zero"}, 32'(a.z), 32'(e.z));
      chk({nm, " in_ready while done"}, 32'(ir), 32'(0));
      chk({nm, " busy while done"}, 32'(bz), 32'(1));
      if (!ld_i) begin
        chk({nm, " latency"}, 32'(cyc - acc), 32'(lat));
        ld_o = 1;
      end
    end
  endtask

  // Every negedge the bench passes through goes via here, so both DUTs are
  // compared on every cycle.
  task automatic tick();
    bit l;
    @(negedge clk);
    cmp_one("u8", pend8, exp8, lat8, acc8, ld8, ov8, {8'h00, r8, c8, v8, n8, z8}, ir8, busy8, l);
    ld8 = l;
    cmp_one("u16", pend16, exp16, lat16, acc16, ld16, ov16, {r16, c16, v16, n16, z16}, ir16, busy16, l);
    ld16 = l;
  endtask

  task automatic run_op(input bit w16, input logic [3:0] o, input logic d, input logic [15:0] a,
                        input logic [15:0] b, input logic ci, input int hold, output res_t got);
    int   k;
    int   w = w16 ? 16 : 8;
    int   lt = (o <= 4'd1 || o >= 4'd13) ? w / 4 : 1;
    res_t e = model(w, o, d, a, b, ci);
    chk("in_ready before request", 32'(w16 ? ir16 : ir8), 32'(1));
    op_s = o; dec_s = d; a_s = a; b_s = b; cin_s = ci;
    if (w16) begin
      exp16 = e; lat16 = lt; acc16 = cyc; ld16 = 0; pend16 = 1; iv16 = 1;
    end else begin
      exp8 = e; lat8 = lt; acc8 = cyc; ld8 = 0; pend8 = 1; iv8 = 1;
    end
    @(posedge clk); #1;
    iv8 = 0; iv16 = 0;
    op_s = 4'($urandom); a_s = 16'($urandom); b_s = 16'($urandom);
    dec_s = 1'($urandom); cin_s = 1'($urandom);
    k = 0;
    do begin
      tick();
      k++;
    end while (!(w16 ? ov16 : ov8) && k < 40);
    if (!(w16 ? ov16 : ov8)) chk("out_valid timeout", 32'(0), 32'(1));
    got = w16 ? {r16, c16, v16, n16, z16} : {8'h00, r8, c8, v8, n8, z8};
    repeat (hold) begin
      tick();
      chk("stall in_ready", 32'(w16 ? ir16 : ir8), 32'(0));
      chk("stall busy", 32'(w16 ? busy16 : busy8), 32'(1));
    end
    if (w16) or16 = 1; else or8 = 1;
    @(posedge clk); #1;
    or8 = 0; or16 = 0;
    if (w16) pend16 = 0; else pend8 = 0;
    tick();
    chk("result held in idle", 32'(w16 ? r16 : {8'h00, r8}), 32'(got.r));
    chk("in_ready after handshake", 32'(w16 ? ir16 : ir8), 32'(1));
  endtask

  initial begin
    res_t        g;
    logic [15:0] prev;

    repeat (2) @(negedge clk);
    chk("reset u8 result", 32'(r8), 32'(0));
    chk("reset u8 flags", 32'({c8, v8, n8, z8}), 32'(0));
    chk("reset u8 out_valid/busy", 32'({ov8, busy8}), 32'(0));
    chk("reset u8 in_ready", 32'(ir8), 32'(1));
    chk("reset u16 result", 32'(r16), 32'(0));
    chk("reset u16 flags", 32'({c16, v16, n16, z16, ov16, busy16}), 32'(0));
    chk("reset u16 in_ready", 32'(ir16), 32'(1));
    rst = 0;
    tick();

    run_op(0, 4'h0, 1, 16'h58, 16'h46, 0, 0, g);
    chk("dec add 58+46 result", 32'(g.r), 32'h04);
    chk("dec add 58+46 C", 32'(g.c), 32'(1));
    chk("dec add 58+46 Z", 32'(g.z), 32'(0));

    run_op(0, 4'h0, 0, 16'h7F, 16'h01, 0, 0, g);
    chk("bin add 7F+01", 32'({g.r, g.c, g.v, g.n}), 32'({16'h80, 1'b0, 1'b1, 1'b1}));

    run_op(0, 4'h1, 1, 16'h12, 16'h21, 1, 0, g);
    chk("dec sub 12-21", 32'({g.r, g.c, g.n}), 32'({16'h91, 1'b0, 1'b1}));

    run_op(0, 4'hD, 1, 16'h10, 16'h09, 0, 0, g);
    chk("cmp 10,09", 32'({g.r, g.c, g.z}), 32'({16'h07, 1'b1, 1'b0}));

    run_op(0, 4'hF, 0, 16'h42, 16'h42, 0, 0, g);
    chk("cmp 42,42", 32'({g.z, g.c}), 32'({1'b1, 1'b1}));

    run_op(0, 4'h1, 0, 16'h30, 16'h50, 1, 5, g);
    chk("bin sub 30-50 held", 32'({g.r, g.c, g.v, g.n}), 32'({16'hE0, 1'b0, 1'b0, 1'b1}));

    run_op(0, 4'h1, 0, 16'h80, 16'h01, 1, 0, g);
    run_op(0, 4'h0, 1, 16'h99, 16'h01, 1, 0, g);
    run_op(0, 4'h2, 0, 16'hF0, 16'h3C, 0, 0, g);
    run_op(0, 4'h3, 0, 16'hF0, 16'h0C, 0, 0, g);
    run_op(0, 4'h4, 0, 16'hFF, 16'h0F, 0, 0, g);
    run_op(0, 4'h5, 0, 16'h81, 16'h00, 0, 0, g);
    run_op(0, 4'h6, 0, 16'h01, 16'h00, 1, 0, g);
    run_op(0, 4'h7, 0, 16'h80, 16'h00, 1, 0, g);
    run_op(0, 4'h8, 0, 16'h01, 16'h00, 0, 0, g);
    run_op(0, 4'h8, 0, 16'h02, 16'h00, 1, 0, g);
    run_op(0, 4'h9, 0, 16'hFF, 16'h00, 1, 0, g);
    run_op(0, 4'hA, 0, 16'h00, 16'h00, 1, 0, g);
    chk("dec 00 wraps", 32'(g.r), 32'hFF);
    run_op(0, 4'hB, 0, 16'h5A, 16'hA5, 0, 0, g);
    run_op(0, 4'hC, 0, 16'h5A, 16'hA5, 0, 0, g);
    run_op(0, 4'hE, 0, 16'h01, 16'h02, 0, 0, g);

    run_op(1, 4'h0, 1, 16'h9999, 16'h0001, 0, 0, g);
    chk("dec add 9999+0001", 32'({g.r, g.c, g.z}), 32'({16'h0000, 1'b1, 1'b1}));
    run_op(1, 4'h9, 0, 16'hFFFF, 16'h0000, 0, 0, g);
    chk("inc FFFF", 32'({g.r, g.c, g.z}), 32'({16'h0000, 1'b0, 1'b1}));
    run_op(1, 4'h1, 1, 16'h1000, 16'h0001, 1, 0, g);
    run_op(1, 4'h0, 0, 16'h7FFF, 16'h0001, 0, 0, g);
    run_op(1, 4'hB, 0, 16'h8421, 16'h0000, 0, 0, g);

    // flush while digits are still being processed: no result may appear
    prev = r16;
    op_s = 4'h0; dec_s = 0; a_s = 16'h1234; b_s = 16'h1111; cin_s = 0; iv16 = 1;
    @(posedge clk); #1;
    iv16 = 0;
    tick();
    chk("busy mid-arith", 32'(busy16), 32'(1));
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    tick();
    chk("flush to idle", 32'({busy16, ir16, ov16}), 32'({1'b0, 1'b1, 1'b0}));
    chk("flush keeps old result", 32'(r16), 32'(prev));
    repeat (5) tick();

    // reset after two digits have been processed
    op_s = 4'h0; a_s = 16'h1111; b_s = 16'h2222; iv16 = 1;
    @(posedge clk); #1;
    iv16 = 0;
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("rst result", 32'(r16), 32'(0));
    chk("rst flags", 32'({c16, v16, n16, z16}), 32'(0));
    chk("rst out_valid/busy", 32'({ov16, busy16}), 32'(0));
    chk("rst in_ready", 32'(ir16), 32'(1));
    tick();
    rst = 0;
    tick();

    run_op(1, 4'h1, 0, 16'h0000, 16'h0001, 1, 0, g);
    chk("bin sub 0000-0001", 32'({g.r, g.c, g.n}), 32'({16'hFFFF, 1'b0, 1'b1}));
    run_op(0, 4'h0, 0, 16'h80, 16'h80, 0, 0, g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
